inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Inverse of the instruction decoder. Accepts field-level instruction commands (class, sub-op, register indices, immediate, func) over a valid/ready interface.
- Packs each command into the 16-bit instruction format the decoder expects and writes it sequentially into instruction memory through a registered write port.
- Sits between the host/debug loader and the IM write port. It is used to load programs before releasing the CPU.

Parameters:
- ADDR_W, 8, IM address width; program capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first IM address written after start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a new load session.
- finish  in  1  pulse: end the session after the pending write drains.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_cls  in  3  class: ALU_CAL=000, ALU_IMM=001, BRANCH=010, BRANCH_JUMP=011, DM_FUN=100; other values are illegal.
- cmd_sub  in  2  sub-op: inst[12:11]. LD=00, SD=01, BIN_SHIFT_IMM=11.
- cmd_rd, cmd_rs0, cmd_rs1  in  3 each  register indices.
- cmd_imm  in  8  immediate.
- cmd_func  in  2  ALU func: inst[1:0] for ALU_CAL only.
- im_w_en  out  1  IM write request.
- im_w_ready  in  1  IM accepts the write this cycle.
- im_w_addr  out  ADDR_W  write address.
- im_w_data  out  16  encoded instruction.
- busy  out  1  state==LOAD.
- done  out  1  state==DONE.
- prog_len  out  ADDR_W+1  number of words written this session.
- err  out  1  sticky: at least one command was rejected.
- err_cnt  out  8  rejected-command count; saturates at 255.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0, the address counter equals BASE_ADDR, and any pending write is discarded.
- FSM states:
  - IDLE --start--> LOAD.
  - LOAD --(finish seen && no pending write) or (last address written)--> DONE.
  - DONE --start--> LOAD.
- start in LOAD is ignored. start on entry to LOAD clears prog_len, err, err_cnt and sets addr=BASE_ADDR.
- finish is latched in LOAD until the pending write drains; the FSM then enters DONE.
- One-entry output register:
  - cmd_ready = (state==LOAD) && !finish_latched && !full && (!im_w_en || im_w_ready).
  - An accepted legal command appears on im_w_en/im_w_data/im_w_addr the next cycle (latency 1).
  - im_w_en holds with stable data and address until im_w_ready=1.
  - On a write handshake: addr++ and prog_len++.
- Encoding: [15:13]=cls and [12:11]=sub for every class. Unused bits are 0.
  - ALU_CAL: [10:8]=rd, [7:5]=rs0, [4:2]=rs1 (imm[2:0] when sub==11), [1:0]=func.
  - ALU_IMM: [10:8]=rd, [7:5]=rs0, [4:0]=imm[4:0].
  - BRANCH: [10:8]=imm[4:2], [7:5]=rs0, [4:2]=rs1, [1:0]=imm[1:0].
  - BRANCH_JUMP: [10:8]=rd, [7:0]=imm.
  - DM_FUN LD (sub==00): [10:8]=rd, [7:0]=imm.
  - DM_FUN SD (sub==01): [10:5]=imm[7:2], [4:2]=rs1, [1:0]=imm[1:0].
- Rejection rules:
  - Rejected when: illegal class; DM_FUN with sub not LD/SD; shift with imm[7:3]!=0; ALU_IMM or BRANCH with imm[7:5]!=0.
  - A rejected command is still handshaked but nothing is written. err is set and err_cnt is incremented (saturating).
- Full: when the word at address 2^ADDR_W-1 completes its write, full=1, cmd_ready drops and the FSM enters DONE. The address never wraps.
- Simultaneous finish and accepted cmd: the command is written, then the FSM enters DONE.
- Reset mid-write: the write is dropped and im_w_en falls immediately (async).

Test Plan:
- Reset, start, then ALU_CAL cls=000 sub=00 rd=3 rs0=5 rs1=6 func=2, im_w_ready=1 -> one cycle later im_w_en=1, addr=0x00, data=0x03BA; prog_len=1.
- SD cls=100 sub=01 imm=0xB7 rs1=2, then BRANCH_JUMP cls=011 sub=00 rd=7 imm=0x40 -> data 0x8DAB at addr 0, then 0x6740 at addr 1.
- Hold im_w_ready=0 for 3 cycles with a pending write -> im_w_en, addr and data stable, cmd_ready=0; release -> write completes and addr increments.
- ALU_IMM imm=0x25, then cls=111 -> no writes, err=1, err_cnt=2, addr unchanged; next legal command lands at BASE_ADDR.
- ADDR_W=2: issue 5 commands -> 4 writes (addr 0..3), done=1, prog_len=4, 5th command never accepted; start -> busy=1, prog_len=0.
- finish asserted with a command in the same cycle, plus an async reset pulse mid-pending-write in a second run -> first run: write lands, then done=1. Second run: all outputs 0 and state IDLE.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// Packs field-level instruction commands into 16-bit words and writes them sequentially into IM.
// Latency 1 from command accept to im_w_en; one-entry output register; cmd_ready drops while a write is stalled.
module inst_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_cls,
  input  logic [1:0]        cmd_sub,
  input  logic [2:0]        cmd_rd,
  input  logic [2:0]        cmd_rs0,
  input  logic [2:0]        cmd_rs1,
  input  logic [7:0]        cmd_imm,
  input  logic [1:0]        cmd_func,
  output logic              im_w_en,
  input  logic              im_w_ready,
  output logic [ADDR_W-1:0] im_w_addr,
  output logic [15:0]       im_w_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = '1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;
  localparam logic [ADDR_W:0]   ONE_L = 1;

  state_t      state, state_nxt;
  logic [15:0] enc;
  logic        legal;
  logic        fin_lat;
  logic        full_q;
  logic        full;
  logic        wr_hs;
  logic        acc;
  logic        start_sess;

  // A pending write to the last address already counts as full so no further command is taken.
  assign full       = full_q || (im_w_en && (im_w_addr == LAST));
  assign wr_hs      = im_w_en && im_w_ready;
  assign cmd_ready  = (state == LOAD) && !fin_lat && !full && (!im_w_en || im_w_ready);
  assign acc        = cmd_valid && cmd_ready;
  assign start_sess = start && (state != LOAD);
  assign busy       = (state == LOAD);
  assign done       = (state == DONE);

  always_comb begin
    enc   = {cmd_cls, cmd_sub, 11'd0};
    legal = 1'b1;
    case (cmd_cls)
      3'b000: begin
        enc[10:0] = {cmd_rd, cmd_rs0, (cmd_sub == 2'b11) ? cmd_imm[2:0] : cmd_rs1, cmd_func};
        if ((cmd_sub == 2'b11) && (cmd_imm[7:3] != 5'd0)) legal = 1'b0;
      end
      3'b001: begin
        enc[10:0] = {cmd_rd, cmd_rs0, cmd_imm[4:0]};
        legal     = (cmd_imm[7:5] == 3'd0);
      end
      3'b010: begin
        enc[10:0] = {cmd_imm[4:2], cmd_rs0, cmd_rs1, cmd_imm[1:0]};
        legal     = (cmd_imm[7:5] == 3'd0);
      end
      3'b011: enc[10:0] = {cmd_rd, cmd_imm};
      3'b100: begin
        if (cmd_sub == 2'b00)      enc[10:0] = {cmd_rd, cmd_imm};
        else if (cmd_sub == 2'b01) enc[10:0] = {cmd_imm[7:2], cmd_rs1, cmd_imm[1:0]};
        else                       legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: if ((fin_lat && !im_w_en) || (wr_hs && (im_w_addr == LAST))) state_nxt = DONE;
      DONE: if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      im_w_en   <= 1'b0;
      im_w_addr <= BASE;
      im_w_data <= 16'd0;
      prog_len  <= '0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
      fin_lat   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_sess) begin
        im_w_en   <= 1'b0;
        im_w_addr <= BASE;
        prog_len  <= '0;
        err       <= 1'b0;
        err_cnt   <= 8'd0;
        fin_lat   <= 1'b0;
        full_q    <= 1'b0;
      end else if (state == LOAD) begin
        if (finish) fin_lat <= 1'b1;
        if (wr_hs) begin
          prog_len <= prog_len + ONE_L;
          if (im_w_addr == LAST) full_q    <= 1'b1;
          else                   im_w_addr <= im_w_addr + ONE_A;
        end
        if (acc && legal) begin
          im_w_en   <= 1'b1;
          im_w_data <= enc;
        end else if (wr_hs) begin
          im_w_en <= 1'b0;
        end
        if (acc && !legal) begin
          err <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: vector table through a write scoreboard plus multi-cycle corner sequences.
module tb_inst_encoder_loader;

  typedef struct {
    logic [2:0]  cls;
    logic [1:0]  sub;
    logic [2:0]  rd, rs0, rs1;
    logic [7:0]  imm;
    logic [1:0]  func;
    bit          legal;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, finish, cmd_valid, im_w_ready, sel;
  logic [2:0] cmd_cls, cmd_rd, cmd_rs0, cmd_rs1;
  logic [1:0] cmd_sub, cmd_func;
  logic [7:0] cmd_imm;

  logic        rdy1, en1, busy1, done1, err1;
  logic [7:0]  addr1, ecnt1;
  logic [15:0] dat1;
  logic [8:0]  plen1;
  logic        rdy2, en2, busy2, done2, err2;
  logic [1:0]  addr2;
  logic [7:0]  ecnt2;
  logic [15:0] dat2;
  logic [2:0]  plen2;

  logic        obs_rdy, obs_en, obs_busy, obs_done, obs_err;
  logic [7:0]  obs_addr, obs_ecnt;
  logic [15:0] obs_dat;
  logic [8:0]  obs_plen;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  bit rnd_rdy = 0;
  logic [7:0] exp_addr;
  logic [23:0] q[$];
  vec_t tbl[14];

  inst_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .finish(finish & ~sel),
    .cmd_valid(cmd_valid & ~sel), .cmd_ready(rdy1), .cmd_cls(cmd_cls), .cmd_sub(cmd_sub),
    .cmd_rd(cmd_rd), .cmd_rs0(cmd_rs0), .cmd_rs1(cmd_rs1), .cmd_imm(cmd_imm), .cmd_func(cmd_func),
    .im_w_en(en1), .im_w_ready(im_w_ready), .im_w_addr(addr1), .im_w_data(dat1),
    .busy(busy1), .done(done1), .prog_len(plen1), .err(err1), .err_cnt(ecnt1));

  inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .finish(finish & sel),
    .cmd_valid(cmd_valid & sel), .cmd_ready(rdy2), .cmd_cls(cmd_cls), .cmd_sub(cmd_sub),
    .cmd_rd(cmd_rd), .cmd_rs0(cmd_rs0), .cmd_rs1(cmd_rs1), .cmd_imm(cmd_imm), .cmd_func(cmd_func),
    .im_w_en(en2), .im_w_ready(im_w_ready), .im_w_addr(addr2), .im_w_data(dat2),
    .busy(busy2), .done(done2), .prog_len(plen2), .err(err2), .err_cnt(ecnt2));

  assign obs_rdy  = sel ? rdy2  : rdy1;
  assign obs_en   = sel ? en2   : en1;
  assign obs_busy = sel ? busy2 : busy1;
  assign obs_done = sel ? done2 : done1;
  assign obs_err  = sel ? err2  : err1;
  assign obs_addr = sel ? {6'd0, addr2} : addr1;
  assign obs_ecnt = sel ? ecnt2 : ecnt1;
  assign obs_dat  = sel ? dat2  : dat1;
  assign obs_plen = sel ? {6'd0, plen2} : plen1;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] cls, input logic [1:0] sub, input logic [2:0] rd,
                              input logic [2:0] rs0, input logic [2:0] rs1, input logic [7:0] imm,
                              input logic [1:0] func, input bit legal, input logic [15:0] exp);
    vec_t v;
    v.cls = cls; v.sub = sub; v.rd = rd; v.rs0 = rs0; v.rs1 = rs1;
    v.imm = imm; v.func = func; v.legal = legal; v.exp = exp;
    return v;
  endfunction

  always @(negedge clk) if (rnd_rdy) im_w_ready = 1'($urandom_range(0, 1));

  // Scoreboard: a write is taken on the coming posedge when en and ready are both high now.
  always @(negedge clk) begin
    logic [23:0] e;
    #2;
    if (rst_n && obs_en && im_w_ready) begin
      wr_cnt++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with empty scoreboard", obs_addr, obs_dat);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(obs_addr), 32'(e[23:16]));
        chk("wr_data", 32'(obs_dat), 32'(e[15:0]));
      end
    end
  end

  task automatic drive(input vec_t v);
    cmd_cls = v.cls; cmd_sub = v.sub; cmd_rd = v.rd; cmd_rs0 = v.rs0;
    cmd_rs1 = v.rs1; cmd_imm = v.imm; cmd_func = v.func;
  endtask

  task automatic send(input vec_t v, output bit acc, input int budget);
    @(negedge clk);
    drive(v);
    cmd_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (obs_rdy) begin
        acc = 1'b1;
        if (v.legal) begin
          q.push_back({exp_addr, v.exp});
          exp_addr++;
        end
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (obs_done) break;
    end
    chk("done_reached", 32'(obs_done), 32'd1);
  endtask

  task automatic start_session();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    exp_addr = 8'd0;
  endtask

  task automatic end_session();
    @(negedge clk) finish = 1'b1;
    @(negedge clk) finish = 1'b0;
    wait_done(20);
  endtask

  initial begin
    bit acc;
    int n_legal, n_illegal, wr0;
    tbl[0]  = mk(3'b000, 2'b00, 3'd3, 3'd5, 3'd6, 8'h00, 2'd2, 1, 16'h03BA);
    tbl[1]  = mk(3'b100, 2'b01, 3'd0, 3'd0, 3'd2, 8'hB7, 2'd0, 1, 16'h8DAB);
    tbl[2]  = mk(3'b011, 2'b00, 3'd7, 3'd0, 3'd0, 8'h40, 2'd0, 1, 16'h6740);
    tbl[3]  = mk(3'b000, 2'b11, 3'd1, 3'd2, 3'd7, 8'h05, 2'd1, 1, 16'h1955);
    tbl[4]  = mk(3'b001, 2'b00, 3'd4, 3'd6, 3'd0, 8'h1A, 2'd0, 1, 16'h24DA);
    tbl[5]  = mk(3'b010, 2'b10, 3'd2, 3'd3, 3'd5, 8'h1D, 2'd3, 1, 16'h5775);
    tbl[6]  = mk(3'b100, 2'b00, 3'd5, 3'd1, 3'd4, 8'h9C, 2'd0, 1, 16'h859C);
    tbl[7]  = mk(3'b001, 2'b10, 3'd7, 3'd0, 3'd7, 8'h1F, 2'd3, 1, 16'h371F);
    tbl[8]  = mk(3'b001, 2'b00, 3'd1, 3'd1, 3'd0, 8'h25, 2'd0, 0, 16'h0000);
    tbl[9]  = mk(3'b111, 2'b00, 3'd1, 3'd1, 3'd1, 8'h00, 2'd0, 0, 16'h0000);
    tbl[10] = mk(3'b101, 2'b01, 3'd2, 3'd2, 3'd2, 8'h01, 2'd1, 0, 16'h0000);
    tbl[11] = mk(3'b100, 2'b10, 3'd3, 3'd0, 3'd1, 8'h11, 2'd0, 0, 16'h0000);
    tbl[12] = mk(3'b000, 2'b11, 3'd1, 3'd2, 3'd3, 8'h08, 2'd0, 0, 16'h0000);
    tbl[13] = mk(3'b010, 2'b00, 3'd0, 3'd4, 3'd5, 8'h20, 2'd0, 0, 16'h0000);

    rst_n = 1'b0; start = 1'b0; finish = 1'b0; cmd_valid = 1'b0; im_w_ready = 1'b0; sel = 1'b0;
    drive(tbl[0]);
    exp_addr = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_en", 32'(obs_en), 0);
    chk("rst_ready", 32'(obs_rdy), 0);
    chk("rst_busy", 32'(obs_busy), 0);
    chk("rst_done", 32'(obs_done), 0);
    chk("rst_prog_len", 32'(obs_plen), 0);
    chk("rst_err", 32'(obs_err), 0);
    chk("rst_err_cnt", 32'(obs_ecnt), 0);
    chk("rst_addr", 32'(obs_addr), 0);
    rst_n = 1'b1;

    // Table session: first vector with a fixed-ready latency check, rest with random ready.
    start_session();
    #1 chk("start_busy", 32'(obs_busy), 1);
    @(negedge clk) im_w_ready = 1'b1;
    send(tbl[0], acc, 20);
    chk("lat1_en", 32'(obs_en), 1);
    chk("lat1_addr", 32'(obs_addr), 0);
    chk("lat1_data", 32'(obs_dat), 32'h03BA);
    @(posedge clk); #1;
    chk("lat1_prog_len", 32'(obs_plen), 1);
    rnd_rdy = 1;
    n_legal = 1; n_illegal = 0;
    for (int i = 1; i < 14; i++) begin
      send(tbl[i], acc, 40);
      chk($sformatf("tbl%0d_accepted", i), 32'(acc), 1);
      if (tbl[i].legal) n_legal++; else n_illegal++;
    end
    rnd_rdy = 0;
    @(negedge clk) im_w_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("tbl_drained", 32'(q.size()), 0);
    chk("tbl_prog_len", 32'(obs_plen), 32'(n_legal));
    chk("tbl_err", 32'(obs_err), 1);
    chk("tbl_err_cnt", 32'(obs_ecnt), 32'(n_illegal));
    start_session();
    #1;
    chk("start_in_load_ignored", 32'(obs_plen), 32'(n_legal));
    end_session();

    // Stalled write holds address and data, blocks new commands.
    start_session();
    @(negedge clk) im_w_ready = 1'b0;
    send(tbl[2], acc, 20);
    @(negedge clk);
    drive(tbl[0]);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_en", 32'(obs_en), 1);
      chk("hold_addr", 32'(obs_addr), 0);
      chk("hold_data", 32'(obs_dat), 32'h6740);
      chk("hold_ready", 32'(obs_rdy), 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    im_w_ready = 1'b1;
    @(negedge clk); #1;
    chk("hold_addr_inc", 32'(obs_addr), 1);
    chk("hold_prog_len", 32'(obs_plen), 1);
    end_session();

    // Rejected commands write nothing; next legal command lands at the base address.
    start_session();
    wr0 = wr_cnt;
    send(tbl[8], acc, 20);
    send(tbl[9], acc, 20);
    repeat (3) @(negedge clk);
    #1;
    chk("rej_err", 32'(obs_err), 1);
    chk("rej_err_cnt", 32'(obs_ecnt), 2);
    chk("rej_addr", 32'(obs_addr), 0);
    chk("rej_no_write", 32'(wr_cnt - wr0), 0);
    send(tbl[4], acc, 20);
    repeat (3) @(negedge clk);
    chk("rej_then_legal_written", 32'(wr_cnt - wr0), 1);
    end_session();

    // Four-word memory fills and refuses the fifth command.
    sel = 1'b1;
    start_session();
    for (int i = 0; i < 4; i++) begin
      send(tbl[i], acc, 20);
      chk("full_accept", 32'(acc), 1);
    end
    send(tbl[4], acc, 8);
    chk("full_fifth_refused", 32'(acc), 0);
    repeat (2) @(negedge clk);
    #1;
    chk("full_done", 32'(obs_done), 1);
    chk("full_prog_len", 32'(obs_plen), 4);
    chk("full_addr_no_wrap", 32'(obs_addr), 3);
    chk("full_drained", 32'(q.size()), 0);
    start_session();
    #1;
    chk("restart_busy", 32'(obs_busy), 1);
    chk("restart_prog_len", 32'(obs_plen), 0);
    sel = 1'b0;

    // finish in the same cycle as an accepted command.
    start_session();
    @(negedge clk);
    drive(tbl[1]);
    cmd_valid = 1'b1;
    finish = 1'b1;
    #1;
    chk("fin_cmd_ready", 32'(obs_rdy), 1);
    q.push_back({exp_addr, tbl[1].exp});
    exp_addr++;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    finish = 1'b0;
    chk("fin_write_pending", 32'(obs_en), 1);
    chk("fin_still_busy", 32'(obs_busy), 1);
    wait_done(10);
    chk("fin_prog_len", 32'(obs_plen), 1);

    // Async reset during a stalled write.
    start_session();
    @(negedge clk) im_w_ready = 1'b0;
    send(tbl[3], acc, 20);
    @(negedge clk); #1;
    chk("arst_pending", 32'(obs_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(obs_en), 0);
    chk("arst_busy", 32'(obs_busy), 0);
    chk("arst_done", 32'(obs_done), 0);
    chk("arst_prog_len", 32'(obs_plen), 0);
    chk("arst_err_cnt", 32'(obs_ecnt), 0);
    chk("arst_addr", 32'(obs_addr), 0);
    chk("arst_data", 32'(obs_dat), 0);
    chk("arst_ready", 32'(obs_rdy), 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("arst_idle_no_busy", 32'(obs_busy), 0);
    chk("final_queue_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
